mac_accum: RTL and testbench

Execute/write-back stage of the PE datapath, directly downstream of the weight-address stage and the weight SRAM. Each enabled cycle it multiplies the weight word returned by the SRAM with the pipelined input activation and accumulates the fixed-point product into an on-chip output-activation register file, indexed by the pipelined output address. It also provides a registered read-out port and a clear command for the layer controller.

---
 rtl/pe_pkg.sv | 12 +
 rtl/fxp_mul.sv | 47 ++++
 rtl/mac_accum.sv | 150 +++++++++++++++
 tb/tb_mac_accum.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE datapath definitions: default widths and common data/address types.
package pe_pkg;

  localparam int unsigned PE_DATA_W = 16;
  localparam int unsigned PE_FRAC_W = 8;
  localparam int unsigned PE_ACT_NO = 16;
  localparam int unsigned PE_ACT_AW = $clog2(PE_ACT_NO);

  typedef logic signed [PE_DATA_W-1:0] data_t;
  typedef logic        [PE_ACT_AW-1:0] addr_t;

endpackage : pe_pkg

// File: rtl/fxp_mul.sv
// Signed fixed-point multiply with arithmetic rescale (floor).
// Build option MAC_SAT_EN: clamp the rescaled product to the DATA_W range and
// flag the clamp; otherwise the product wraps to DATA_W bits.
module fxp_mul
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned FRAC_W = PE_FRAC_W
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] prod_c_o,
  output logic                     sat_c_o
);

  localparam int unsigned FULL_W = 2 * DATA_W;

  logic signed [FULL_W-1:0] full_c;

  assign full_c = FULL_W'(a_i) * FULL_W'(b_i);

`ifdef MAC_SAT_EN
  localparam logic signed [FULL_W-1:0] P_MAX = FULL_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [FULL_W-1:0] P_MIN = ~P_MAX;

  logic signed [FULL_W-1:0] shr_c;

  assign shr_c = full_c >>> FRAC_W;

  // Clamp the rescaled product into the representable DATA_W range.
  always_comb begin
    prod_c_o = DATA_W'(shr_c);
    sat_c_o  = 1'b0;
    if (shr_c > P_MAX) begin
      prod_c_o = DATA_W'(P_MAX);
      sat_c_o  = 1'b1;
    end else if (shr_c < P_MIN) begin
      prod_c_o = DATA_W'(P_MIN);
      sat_c_o  = 1'b1;
    end
  end
`else
  assign prod_c_o = DATA_W'(full_c >>> FRAC_W);
  assign sat_c_o  = 1'b0;
`endif

endmodule : fxp_mul

// File: rtl/mac_accum.sv
// PE execute/write-back stage: multiply weight by activation (stage P), then
// read-modify-write the addressed accumulator entry (stage A). Provides a
// write-first registered read-out port and a synchronous clear.
// Build option MAC_SAT_EN: saturating product/sum with sticky ovf flag;
// without it, arithmetic wraps and ovf stays 0.
module mac_accum
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned FRAC_W = PE_FRAC_W,
  parameter int unsigned ACT_NO = PE_ACT_NO,
  parameter int unsigned ACT_AW = PE_ACT_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     comp_en_mem,
  input  logic signed [DATA_W-1:0] in_act_value_mem,
  input  logic        [ACT_AW-1:0] out_act_addr_mem,
  input  logic signed [DATA_W-1:0] w_mem_q,
  input  logic                     acc_clr,
  input  logic                     rd_en,
  input  logic        [ACT_AW-1:0] rd_addr,
  output logic        [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     ovf
);

  logic signed [DATA_W-1:0] prod_c;
  logic                     prod_sat_c;

  logic signed [DATA_W-1:0] prod_q;
  logic        [ACT_AW-1:0] addr_q;
  logic                     prod_vld_q;
  logic                     prod_sat_q;

  logic signed [DATA_W-1:0] acc_q [ACT_NO];
  logic signed [DATA_W-1:0] acc_old_c;
  logic signed [DATA_W-1:0] acc_wr_d;
  logic                     sum_sat_c;

  logic        [DATA_W-1:0] rd_data_q;
  logic        [DATA_W-1:0] rd_data_d;
  logic                     rd_valid_q;
  logic                     ovf_q;
  logic                     ovf_d;

  fxp_mul #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_fxp_mul (
    .a_i      (w_mem_q),
    .b_i      (in_act_value_mem),
    .prod_c_o (prod_c),
    .sat_c_o  (prod_sat_c)
  );

  // Stage P: capture the rescaled product and its target entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      addr_q     <= '0;
      prod_vld_q <= 1'b0;
      prod_sat_q <= 1'b0;
    end else begin
      prod_vld_q <= comp_en_mem;
      prod_sat_q <= comp_en_mem & prod_sat_c;
      if (comp_en_mem) begin
        prod_q <= prod_c;
        addr_q <= out_act_addr_mem;
      end
    end
  end

  assign acc_old_c = acc_q[addr_q];

`ifdef MAC_SAT_EN
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W - 1){1'b1}}};

  logic signed [DATA_W:0] sum_wide_c;

  assign sum_wide_c = (DATA_W + 1)'(acc_old_c) + (DATA_W + 1)'(prod_q);

  // Stage A sum with one guard bit; clamp when the guard disagrees with the sign.
  always_comb begin
    sum_sat_c = sum_wide_c[DATA_W] ^ sum_wide_c[DATA_W-1];
    acc_wr_d  = sum_wide_c[DATA_W-1:0];
    if (sum_sat_c) begin
      acc_wr_d = sum_wide_c[DATA_W] ? ~S_MAX : S_MAX;
    end
  end
`else
  assign acc_wr_d  = acc_old_c + prod_q;
  assign sum_sat_c = 1'b0;
`endif

  // Stage A: accumulator file; clear wins over a concurrent write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ACT_NO; i++) begin
        acc_q[i] <= '0;
      end
    end else if (acc_clr) begin
      for (int unsigned i = 0; i < ACT_NO; i++) begin
        acc_q[i] <= '0;
      end
    end else if (prod_vld_q) begin
      acc_q[addr_q] <= acc_wr_d;
    end
  end

  // Read-out mux (write-first against stage A) and sticky overflow update.
  always_comb begin
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    if (rd_en) begin
      if (acc_clr) begin
        rd_data_d = '0;
      end else if (prod_vld_q && (addr_q == rd_addr)) begin
        rd_data_d = acc_wr_d;
      end else begin
        rd_data_d = acc_q[rd_addr];
      end
    end
    if (acc_clr) begin
      ovf_d = 1'b0;
    end else if (prod_vld_q && (prod_sat_q || sum_sat_c)) begin
      ovf_d = 1'b1;
    end
  end

  // Registered read-out port and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = prod_vld_q;
  assign ovf      = ovf_q;

endmodule : mac_accum

// File: tb/tb_mac_accum.sv
// Scoreboard bench for mac_accum: reads push expected data, a monitor checks
// each rd_valid beat against the queue (value and arrival cycle).
module tb_mac_accum;

  typedef struct {
    logic [15:0] val;
    int          due;
    string       nm;
  } exp_t;

  exp_t sb_q[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        comp_en_mem;
  logic [15:0] in_act_value_mem;
  logic [3:0]  out_act_addr_mem;
  logic [15:0] w_mem_q;
  logic        acc_clr;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        ovf;

  int n_vec   = 0;
  int n_miss  = 0;
  int cyc_cnt = 0;
  int bcnt;

`ifdef MAC_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
  localparam logic        OVF_EXP = 1'b1;
`else
  localparam logic [15:0] SAT_EXP = 16'h0200;
  localparam logic        OVF_EXP = 1'b0;
`endif

  mac_accum #(
    .DATA_W (16),
    .FRAC_W (8),
    .ACT_NO (16),
    .ACT_AW (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .comp_en_mem      (comp_en_mem),
    .in_act_value_mem (in_act_value_mem),
    .out_act_addr_mem (out_act_addr_mem),
    .w_mem_q          (w_mem_q),
    .acc_clr          (acc_clr),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .busy             (busy),
    .ovf              (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [15:0] w, input logic [15:0] a,
                     input logic [3:0] ad, input logic clr, input logic rd,
                     input logic [3:0] ra, input logic [15:0] ex, input string nm);
    comp_en_mem      = en;
    w_mem_q          = w;
    in_act_value_mem = a;
    out_act_addr_mem = ad;
    acc_clr          = clr;
    rd_en            = rd;
    rd_addr          = ra;
    if (rd) sb_q.push_back('{ex, cyc_cnt + 1, nm});
    @(negedge clk);
  endtask

  task automatic mac(input logic [15:0] w, input logic [15:0] a, input logic [3:0] ad);
    cyc(1'b1, w, a, ad, 1'b0, 1'b0, 4'd0, 16'h0, "");
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0, "");
  endtask

  task automatic rd(input logic [3:0] ra, input logic [15:0] ex, input string nm);
    cyc(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1, ra, ex, nm);
  endtask

  // Monitor: match every read-out beat against the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb_q.size() > 0 && sb_q[0].due < cyc_cnt) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s: rd_valid absent, due cycle %0d now %0d", sb_q[0].nm, sb_q[0].due, cyc_cnt);
        void'(sb_q.pop_front());
      end
      if (rd_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_rd_valid: got rd_data 0x%0h expected no beat", rd_data);
        end else begin
          e = sb_q.pop_front();
          check(e.nm, 32'(rd_data), 32'(e.val));
          check({e.nm, "_lat"}, 32'(cyc_cnt), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    comp_en_mem = 1'b0; in_act_value_mem = '0; out_act_addr_mem = '0;
    w_mem_q = '0; acc_clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_rd_data",  32'(rd_data),  32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_ovf",      32'(ovf),      32'h0);

    // 2.0 * 1.5 = 3.0; read issued in the write cycle sees it
    mac(16'h0200, 16'h0180, 4'd5);
    check("single_busy", 32'(busy), 32'h1);
    rd(4'd5, 16'h0300, "single_wf");
    idle();
    rd(4'd5, 16'h0300, "single_rd");
    idle();

    // Four back-to-back 1.0*1.0 to one entry
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      mac(16'h0100, 16'h0100, 4'd3);
      bcnt += int'(busy);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      bcnt += int'(busy);
    end
    check("b2b_busy_cycles", 32'(bcnt), 32'd4);
    rd(4'd3, 16'h0400, "b2b_acc");
    idle();

    // -0.5 * (1/256) floors to -1 LSB
    mac(16'hFF80, 16'h0001, 4'd9);
    idle();
    rd(4'd9, 16'hFFFF, "neg_floor");
    idle();

    // 127.0 * 127.0 twice: clamps with saturation, wraps without
    mac(16'h7F00, 16'h7F00, 4'd0);
    mac(16'h7F00, 16'h7F00, 4'd0);
    idle();
    check("sat_ovf", 32'(ovf), 32'(OVF_EXP));
    rd(4'd0, SAT_EXP, "sat_acc");
    idle();

    // Clear colliding with a stage-A write; the stage-P operand survives
    mac(16'h0200, 16'h0200, 4'd2);
    idle();
    rd(4'd2, 16'h0400, "pre_clr");
    mac(16'h0200, 16'h0200, 4'd2);
    cyc(1'b1, 16'h0100, 16'h0100, 4'd2, 1'b1, 1'b1, 4'd2, 16'h0000, "clr_rd");
    check("clr_ovf",  32'(ovf),  32'h0);
    check("clr_busy", 32'(busy), 32'h1);
    rd(4'd2, 16'h0100, "clr_keep_wf");
    idle();
    rd(4'd2, 16'h0100, "clr_keep");
    rd(4'd5, 16'h0000, "clr_other");
    idle();

    // Write-first read: 0x0200 + 0x0100 in the read cycle
    mac(16'h0200, 16'h0100, 4'd7);
    idle();
    mac(16'h0100, 16'h0100, 4'd7);
    rd(4'd7, 16'h0300, "wf_read");
    idle();

    // Reset while a product is in flight
    mac(16'h0100, 16'h0100, 4'd4);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    comp_en_mem = 1'b0;
    rd_en = 1'b0;
    #1;
    check("midrst_rd_data",  32'(rd_data),  32'h0);
    check("midrst_rd_valid", 32'(rd_valid), 32'h0);
    check("midrst_busy",     32'(busy),     32'h0);
    check("midrst_ovf",      32'(ovf),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    idle();
    check("post_rst_busy", 32'(busy), 32'h0);
    rd(4'd4, 16'h0000, "rst_no_acc");
    rd(4'd7, 16'h0000, "rst_cleared");
    idle();
    idle();

    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mac_accum
